// File: rtl/rob_mp.sv
// rob_mp: multi-port reorder buffer.
//   Allocates up to DISP_W entries per cycle, accepts WB_PORTS completions,
//   retires up to COMMIT_W entries in order (at most one store per cycle).
//   It also hands a faulting head entry to the exception logic, and it
//   supports partial squash after a mispredicted branch and full flush.
// Ports:
//   clk, reset           clock, asynchronous active-high reset
//   alloc_*              dispatch group in; alloc_ready / alloc_idx out
//   wb_*                 writeback (done / exception) strobes
//   commit_*             retired entry fields per commit slot
//   exc_valid/pc/idx     registered one-cycle exception handoff
//   squash_en/idx        discard entries younger than squash_idx
//   flush_en             discard every entry
//   occupancy, rob_empty, rob_full   fill status
module rob_mp #(
  parameter int unsigned ROB_SIZE = 32,
  parameter int unsigned DISP_W   = 2,
  parameter int unsigned COMMIT_W = 2,
  parameter int unsigned WB_PORTS = 3,
  parameter int unsigned PREG_W   = 6,
  parameter int unsigned IDX_W    = $clog2(ROB_SIZE)
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic [DISP_W-1:0]                alloc_valid,
  input  logic [DISP_W-1:0][4:0]           alloc_arch_rd,
  input  logic [DISP_W-1:0][PREG_W-1:0]    alloc_phys_rd,
  input  logic [DISP_W-1:0]                alloc_is_store,
  input  logic [DISP_W-1:0]                alloc_is_load,
  input  logic [DISP_W-1:0]                alloc_is_branch,
  input  logic [DISP_W-1:0][31:0]          alloc_pc,
  output logic                             alloc_ready,
  output logic [DISP_W-1:0][IDX_W-1:0]     alloc_idx,
  input  logic [WB_PORTS-1:0]              wb_valid,
  input  logic [WB_PORTS-1:0][IDX_W-1:0]   wb_idx,
  input  logic [WB_PORTS-1:0]              wb_exc,
  output logic [COMMIT_W-1:0]              commit_valid,
  output logic [COMMIT_W-1:0][4:0]         commit_arch_rd,
  output logic [COMMIT_W-1:0][PREG_W-1:0]  commit_phys_rd,
  output logic [COMMIT_W-1:0]              commit_is_store,
  output logic [COMMIT_W-1:0]              commit_is_load,
  output logic [COMMIT_W-1:0]              commit_is_branch,
  output logic [COMMIT_W-1:0][31:0]        commit_pc,
  output logic                             exc_valid,
  output logic [31:0]                      exc_pc,
  output logic [IDX_W-1:0]                 exc_idx,
  input  logic                             squash_en,
  input  logic [IDX_W-1:0]                 squash_idx,
  input  logic                             flush_en,
  output logic [IDX_W:0]                   occupancy,
  output logic                             rob_empty,
  output logic                             rob_full
);

  localparam logic [IDX_W:0] SIZE_P = (IDX_W+1)'(ROB_SIZE);
  localparam logic [IDX_W:0] DISP_P = (IDX_W+1)'(DISP_W);
  localparam logic [IDX_W:0] ONE_P  = (IDX_W+1)'(1);

  logic [IDX_W:0]        head, tail;
  logic [IDX_W-1:0]      head_idx, tail_idx;

  logic [ROB_SIZE-1:0]   ent_valid, ent_done, ent_exc;
  logic [ROB_SIZE-1:0]   ent_store, ent_load, ent_branch;
  logic [4:0]            ent_arch [ROB_SIZE];
  logic [PREG_W-1:0]     ent_phys [ROB_SIZE];
  logic [31:0]           ent_pc   [ROB_SIZE];

  logic [ROB_SIZE-1:0]   ent_live;
  logic                  exc_pending;
  logic                  sq_live;
  logic [IDX_W-1:0]      sq_off;
  logic [IDX_W:0]        commit_cnt;
  logic [IDX_W:0]        alloc_cnt;
  logic                  alloc_fire;

  assign head_idx  = head[IDX_W-1:0];
  assign tail_idx  = tail[IDX_W-1:0];
  assign occupancy = tail - head;
  assign rob_empty = (occupancy == '0);
  assign rob_full  = (occupancy == SIZE_P);

  // An entry is live only when valid and inside the head..tail window.
  always_comb begin : live_calc
    logic [IDX_W-1:0] off;
    ent_live = '0;
    off      = '0;
    for (int unsigned i = 0; i < ROB_SIZE; i++) begin
      off         = IDX_W'(i) - head_idx;
      ent_live[i] = ent_valid[i] && ({1'b0, off} < occupancy);
    end
  end

  assign exc_pending = ent_live[head_idx] && ent_done[head_idx] && ent_exc[head_idx];
  assign sq_off      = squash_idx - head_idx;
  assign sq_live     = squash_en && ent_live[squash_idx];

  assign alloc_ready = ((SIZE_P - occupancy) >= DISP_P) && !squash_en && !flush_en && !exc_pending;
  assign alloc_fire  = (|alloc_valid) && alloc_ready;

  // Compacted allocation: requested slots take consecutive indices from tail.
  always_comb begin : alloc_calc
    logic [IDX_W:0] cnt;
    cnt       = '0;
    alloc_idx = '0;
    for (int unsigned k = 0; k < DISP_W; k++) begin
      alloc_idx[k] = tail_idx + cnt[IDX_W-1:0];
      if (alloc_valid[k]) cnt = cnt + ONE_P;
    end
    alloc_cnt = cnt;
  end

  // Commit is an in-order prefix; once a slot is blocked every later slot is
  // blocked too. Under a live squash only surviving entries may retire.
  always_comb begin : commit_calc
    logic [IDX_W-1:0] e;
    logic [IDX_W:0]   stores;
    logic             ok;
    logic [IDX_W:0]   cnt;
    ok               = 1'b1;
    stores           = '0;
    cnt              = '0;
    e                = '0;
    commit_valid     = '0;
    commit_arch_rd   = '0;
    commit_phys_rd   = '0;
    commit_is_store  = '0;
    commit_is_load   = '0;
    commit_is_branch = '0;
    commit_pc        = '0;
    for (int unsigned j = 0; j < COMMIT_W; j++) begin
      e = head_idx + IDX_W'(j);
      if (ent_store[e]) stores = stores + ONE_P;
      ok = ok && ent_live[e] && ent_done[e] && !ent_exc[e]
              && ((IDX_W+1)'(j) < occupancy)
              && (stores <= ONE_P)
              && !(sq_live && ({1'b0, sq_off} < (IDX_W+1)'(j)));
      commit_valid[j]     = ok && !flush_en;
      commit_arch_rd[j]   = ent_arch[e];
      commit_phys_rd[j]   = ent_phys[e];
      commit_is_store[j]  = ent_store[e];
      commit_is_load[j]   = ent_load[e];
      commit_is_branch[j] = ent_branch[e];
      commit_pc[j]        = ent_pc[e];
      if (commit_valid[j]) cnt = cnt + ONE_P;
    end
    commit_cnt = cnt;
  end

  // Control state. Later assignments in the same branch override earlier
  // ones, so squash invalidation wins over a writeback to a discarded entry.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head      <= '0;
      tail      <= '0;
      ent_valid <= '0;
      ent_done  <= '0;
      ent_exc   <= '0;
      exc_valid <= 1'b0;
      exc_pc    <= '0;
      exc_idx   <= '0;
    end else begin
      exc_valid <= 1'b0;
      if (flush_en) begin
        ent_valid <= '0;
        head      <= tail;
      end else if (exc_pending) begin
        exc_valid <= 1'b1;
        exc_pc    <= ent_pc[head_idx];
        exc_idx   <= head_idx;
        ent_valid <= '0;
        head      <= tail;
      end else begin
        for (int unsigned p = 0; p < WB_PORTS; p++) begin
          if (wb_valid[p] && ent_live[wb_idx[p]]) begin
            ent_done[wb_idx[p]] <= 1'b1;
            if (wb_exc[p]) ent_exc[wb_idx[p]] <= 1'b1;
          end
        end
        for (int unsigned j = 0; j < COMMIT_W; j++) begin
          if (commit_valid[j]) ent_valid[head_idx + IDX_W'(j)] <= 1'b0;
        end
        head <= head + commit_cnt;
        if (sq_live) begin
          for (int unsigned i = 0; i < ROB_SIZE; i++) begin
            if ((IDX_W'(i) - head_idx) > sq_off) ent_valid[i] <= 1'b0;
          end
          // Rebuilding from head keeps the wrap bit consistent.
          tail <= head + {1'b0, sq_off} + ONE_P;
        end else if (alloc_fire) begin
          for (int unsigned k = 0; k < DISP_W; k++) begin
            if (alloc_valid[k]) begin
              ent_valid[alloc_idx[k]] <= 1'b1;
              ent_done[alloc_idx[k]]  <= 1'b0;
              ent_exc[alloc_idx[k]]   <= 1'b0;
            end
          end
          tail <= tail + alloc_cnt;
        end
      end
    end
  end

  // Payload storage needs no reset; it is only observed through live entries.
  always_ff @(posedge clk) begin
    if (alloc_fire) begin
      for (int unsigned k = 0; k < DISP_W; k++) begin
        if (alloc_valid[k]) begin
          ent_arch[alloc_idx[k]]   <= alloc_arch_rd[k];
          ent_phys[alloc_idx[k]]   <= alloc_phys_rd[k];
          ent_pc[alloc_idx[k]]     <= alloc_pc[k];
          ent_store[alloc_idx[k]]  <= alloc_is_store[k];
          ent_load[alloc_idx[k]]   <= alloc_is_load[k];
          ent_branch[alloc_idx[k]] <= alloc_is_branch[k];
        end
      end
    end
  end

endmodule

// File: tb/tb_rob_mp.sv
// tb_rob_mp: randomized bench for rob_mp against a queue-based model of the
// in-flight instruction window.
module tb_rob_mp;

  logic              clk = 1'b0;
  logic              reset;
  logic [1:0]        alloc_valid;
  logic [1:0][4:0]   alloc_arch_rd;
  logic [1:0][5:0]   alloc_phys_rd;
  logic [1:0]        alloc_is_store, alloc_is_load, alloc_is_branch;
  logic [1:0][31:0]  alloc_pc;
  logic              alloc_ready;
  logic [1:0][4:0]   alloc_idx;
  logic [2:0]        wb_valid;
  logic [2:0][4:0]   wb_idx;
  logic [2:0]        wb_exc;
  logic [1:0]        commit_valid;
  logic [1:0][4:0]   commit_arch_rd;
  logic [1:0][5:0]   commit_phys_rd;
  logic [1:0]        commit_is_store, commit_is_load, commit_is_branch;
  logic [1:0][31:0]  commit_pc;
  logic              exc_valid;
  logic [31:0]       exc_pc;
  logic [4:0]        exc_idx;
  logic              squash_en;
  logic [4:0]        squash_idx;
  logic              flush_en;
  logic [5:0]        occupancy;
  logic              rob_empty, rob_full;

  rob_mp #(.ROB_SIZE(32), .DISP_W(2), .COMMIT_W(2), .WB_PORTS(3), .PREG_W(6)) dut (
    .clk(clk), .reset(reset),
    .alloc_valid(alloc_valid), .alloc_arch_rd(alloc_arch_rd), .alloc_phys_rd(alloc_phys_rd),
    .alloc_is_store(alloc_is_store), .alloc_is_load(alloc_is_load), .alloc_is_branch(alloc_is_branch),
    .alloc_pc(alloc_pc), .alloc_ready(alloc_ready), .alloc_idx(alloc_idx),
    .wb_valid(wb_valid), .wb_idx(wb_idx), .wb_exc(wb_exc),
    .commit_valid(commit_valid), .commit_arch_rd(commit_arch_rd), .commit_phys_rd(commit_phys_rd),
    .commit_is_store(commit_is_store), .commit_is_load(commit_is_load),
    .commit_is_branch(commit_is_branch), .commit_pc(commit_pc),
    .exc_valid(exc_valid), .exc_pc(exc_pc), .exc_idx(exc_idx),
    .squash_en(squash_en), .squash_idx(squash_idx), .flush_en(flush_en),
    .occupancy(occupancy), .rob_empty(rob_empty), .rob_full(rob_full)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic [4:0]  arch;
    logic [5:0]  phys;
    bit          st, ld, br, done, exc;
  } ent_t;

  ent_t        q[$];
  int unsigned head_seq = 0;
  int unsigned checks = 0;
  int unsigned errors = 0;

  // Expectations derived in the combinational check, reused at the edge.
  bit          m_pend, m_sq_live, m_ready;
  int unsigned m_sq_pos, m_n;
  bit          exp_exc_valid = 1'b0;
  logic [31:0] exp_exc_pc = '0;
  logic [4:0]  exp_exc_idx = '0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic int unsigned pos_of(input logic [4:0] idx);
    return (int'(idx) + 32 - (head_seq % 32)) % 32;
  endfunction

  task automatic clear_inputs();
    alloc_valid = '0; alloc_arch_rd = '0; alloc_phys_rd = '0;
    alloc_is_store = '0; alloc_is_load = '0; alloc_is_branch = '0; alloc_pc = '0;
    wb_valid = '0; wb_idx = '0; wb_exc = '0;
    squash_en = 1'b0; squash_idx = '0; flush_en = 1'b0;
  endtask

  // mode 0: random traffic, mode 1: fill only, mode 2: flush only
  task automatic drive(input int mode);
    int unsigned size, hi, pos;
    clear_inputs();
    size = q.size();
    for (int k = 0; k < 2; k++) begin
      alloc_arch_rd[k]   = 5'($urandom);
      alloc_phys_rd[k]   = 6'($urandom);
      alloc_pc[k]        = $urandom;
      alloc_is_store[k]  = ($urandom_range(0, 2) == 0);
      alloc_is_load[k]   = !alloc_is_store[k] && ($urandom_range(0, 1) == 0);
      alloc_is_branch[k] = ($urandom_range(0, 5) == 0);
    end
    if (mode == 1) begin
      alloc_valid = 2'b11;
    end else if (mode == 2) begin
      flush_en = 1'b1;
    end else begin
      alloc_valid = 2'($urandom);
      for (int p = 0; p < 3; p++) begin
        wb_valid[p] = ($urandom_range(0, 1) == 1);
        if (size > 0 && $urandom_range(0, 5) != 0) begin
          hi  = (size > 6) ? 5 : size - 1;
          pos = $urandom_range(0, hi);
          wb_idx[p] = 5'((head_seq + pos) % 32);
        end else begin
          wb_idx[p] = 5'($urandom);
        end
        wb_exc[p] = ($urandom_range(0, 59) == 0);
      end
      if ($urandom_range(0, 24) == 0) begin
        squash_en  = 1'b1;
        squash_idx = 5'((head_seq + $urandom_range(0, size + 2)) % 32);
      end
      flush_en = ($urandom_range(0, 99) == 0);
    end
  endtask

  task automatic check_comb();
    int unsigned size, tidx, stores, pre;
    size      = q.size();
    tidx      = (head_seq + size) % 32;
    m_pend    = (size > 0) && q[0].done && q[0].exc;
    m_sq_pos  = pos_of(squash_idx);
    m_sq_live = squash_en && (m_sq_pos < size);
    m_ready   = ((32 - size) >= 2) && !squash_en && !flush_en && !m_pend;
    m_n = 0;
    stores = 0;
    for (int unsigned j = 0; j < 2; j++) begin
      if (j >= size) break;
      if (!q[j].done || q[j].exc) break;
      if (q[j].st && stores >= 1) break;
      if (m_sq_live && j > m_sq_pos) break;
      if (q[j].st) stores++;
      m_n++;
    end
    if (flush_en) m_n = 0;
    check_eq("occupancy", 64'(occupancy), 64'(size));
    check_eq("rob_empty", 64'(rob_empty), 64'(size == 0));
    check_eq("rob_full", 64'(rob_full), 64'(size == 32));
    check_eq("alloc_ready", 64'(alloc_ready), 64'(m_ready));
    check_eq("commit_valid", 64'(commit_valid), 64'((1 << m_n) - 1));
    pre = 0;
    for (int k = 0; k < 2; k++) begin
      if (alloc_valid[k]) begin
        check_eq($sformatf("alloc_idx%0d", k), 64'(alloc_idx[k]), 64'((tidx + pre) % 32));
        pre++;
      end
    end
    for (int unsigned j = 0; j < m_n; j++) begin
      check_eq($sformatf("commit_pc%0d", j), 64'(commit_pc[j]), 64'(q[j].pc));
      check_eq($sformatf("commit_rd%0d", j),
               64'({commit_arch_rd[j], commit_phys_rd[j], commit_is_store[j], commit_is_load[j], commit_is_branch[j]}),
               64'({q[j].arch, q[j].phys, q[j].st, q[j].ld, q[j].br}));
    end
  endtask

  task automatic check_regs();
    check_eq("exc_valid", 64'(exc_valid), 64'(exp_exc_valid));
    check_eq("exc_pc", 64'(exc_pc), 64'(exp_exc_pc));
    check_eq("exc_idx", 64'(exc_idx), 64'(exp_exc_idx));
  endtask

  task automatic model_step();
    int unsigned size, pos;
    ent_t e;
    size = q.size();
    exp_exc_valid = 1'b0;
    if (flush_en) begin
      head_seq += size;
      q.delete();
    end else if (m_pend) begin
      exp_exc_valid = 1'b1;
      exp_exc_pc    = q[0].pc;
      exp_exc_idx   = 5'(head_seq % 32);
      head_seq += size;
      q.delete();
    end else begin
      for (int p = 0; p < 3; p++) begin
        if (wb_valid[p]) begin
          pos = pos_of(wb_idx[p]);
          if (pos < size) begin
            e = q[pos];
            e.done = 1'b1;
            if (wb_exc[p]) e.exc = 1'b1;
            q[pos] = e;
          end
        end
      end
      if (m_sq_live) begin
        while (q.size() > m_sq_pos + 1) void'(q.pop_back());
      end
      for (int unsigned j = 0; j < m_n; j++) void'(q.pop_front());
      head_seq += m_n;
      if (!m_sq_live && m_ready) begin
        for (int k = 0; k < 2; k++) begin
          if (alloc_valid[k]) begin
            e.pc = alloc_pc[k]; e.arch = alloc_arch_rd[k]; e.phys = alloc_phys_rd[k];
            e.st = alloc_is_store[k]; e.ld = alloc_is_load[k]; e.br = alloc_is_branch[k];
            e.done = 1'b0; e.exc = 1'b0;
            q.push_back(e);
          end
        end
      end
    end
  endtask

  task automatic cycle(input int mode);
    @(negedge clk);
    check_regs();
    drive(mode);
    #1;
    check_comb();
    model_step();
  endtask

  initial begin
    clear_inputs();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    #1;
    check_eq("rst_occupancy", 64'(occupancy), 64'(0));
    check_eq("rst_alloc_ready", 64'(alloc_ready), 64'(1));
    check_eq("rst_rob_empty", 64'(rob_empty), 64'(1));
    check_eq("rst_rob_full", 64'(rob_full), 64'(0));
    check_eq("rst_commit_valid", 64'(commit_valid), 64'(0));
    check_eq("rst_exc_valid", 64'(exc_valid), 64'(0));
    check_eq("rst_exc_pc", 64'(exc_pc), 64'(0));
    check_eq("rst_exc_idx", 64'(exc_idx), 64'(0));

    // Fill to capacity, then keep requesting while full.
    repeat (18) cycle(1);
    #1;
    check_eq("full_occupancy", 64'(occupancy), 64'(32));
    check_eq("full_flag", 64'(rob_full), 64'(1));
    check_eq("full_ready", 64'(alloc_ready), 64'(0));
    cycle(2);

    repeat (4000) cycle(0);
    @(negedge clk);
    check_regs();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
